// File: rtl/track_segment_arbiter.sv
// Round-robin owner of one single-track segment: grant, switch settle,
// occupancy watchdog with latched fault, dead time before the next grant.
//
// Ports:
//   Clock      in   rising-edge clock
//   RESET_N    in   asynchronous active-low reset
//   REQ        in   [NUM_TRAINS]   train i waiting at entry (level)
//   EXIT       in   [NUM_TRAINS]   train i sensed at exit (level)
//   FAULT_CLR  in   operator clear of a latched fault
//   SW         out  [SW_W]         switch setting = granted train index
//   D          out  [2*NUM_TRAINS] per-train drive, 01=go 00=stop
//   GRANT      out  [NUM_TRAINS]   one-hot segment owner, 0 when free
//   BUSY       out  arbiter not idle
//   FAULT      out  occupancy timeout latched
module track_segment_arbiter #(
    parameter int NUM_TRAINS     = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int CLEAR_CYCLES   = 2,
    parameter int MAX_OCC_CYCLES = 1000,
    parameter int CNT_W          = 16,
    localparam int SW_W          = $clog2(NUM_TRAINS)
) (
    input  logic                    Clock,
    input  logic                    RESET_N,
    input  logic [NUM_TRAINS-1:0]   REQ,
    input  logic [NUM_TRAINS-1:0]   EXIT,
    input  logic                    FAULT_CLR,
    output logic [SW_W-1:0]         SW,
    output logic [2*NUM_TRAINS-1:0] D,
    output logic [NUM_TRAINS-1:0]   GRANT,
    output logic                    BUSY,
    output logic                    FAULT
);

    localparam int DW = 2 * NUM_TRAINS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_OCC,
        S_CLEAR,
        S_FAULT
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        timer_q;
    logic [SW_W-1:0]         ptr_q;
    logic [SW_W-1:0]         sw_q;
    logic [DW-1:0]           d_q;
    logic [NUM_TRAINS-1:0]   grant_q;
    logic                    busy_q;
    logic                    fault_q;

    logic                    pick_vld;
    logic [SW_W-1:0]         pick_idx;
    logic [SW_W-1:0]         ptr_d;
    logic [CNT_W-1:0]        timer_inc;
    int                      cand;

    // First requester at or above the pointer, wrapping to train 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int i = 0; i < NUM_TRAINS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_TRAINS) cand = cand - NUM_TRAINS;
            if (!pick_vld && REQ[cand]) begin
                pick_vld = 1'b1;
                pick_idx = SW_W'(cand);
            end
        end
    end

    assign ptr_d = (sw_q == SW_W'(NUM_TRAINS - 1)) ? '0 : sw_q + SW_W'(1);

    // Saturating count; never wraps back to zero.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

    always_ff @(posedge Clock or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            ptr_q   <= '0;
            sw_q    <= '0;
            d_q     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_q <= S_SETTLE;
                        timer_q <= '0;
                        sw_q    <= pick_idx;
                        grant_q <= NUM_TRAINS'(1) << pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    // A train backing off before go must never see 01.
                    if (!REQ[sw_q]) begin
                        state_q <= S_IDLE;
                        timer_q <= '0;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (timer_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_q <= S_OCC;
                        timer_q <= '0;
                        d_q     <= DW'(1) << {sw_q, 1'b0};
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                S_OCC: begin
                    // Exit beats a timeout landing on the same cycle.
                    if (EXIT[sw_q]) begin
                        state_q <= S_CLEAR;
                        timer_q <= '0;
                        d_q     <= '0;
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                    end else if (timer_q == CNT_W'(MAX_OCC_CYCLES - 1)) begin
                        state_q <= S_FAULT;
                        timer_q <= '0;
                        d_q     <= '0;
                        grant_q <= '0;
                        fault_q <= 1'b1;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                S_CLEAR: begin
                    if (timer_q == CNT_W'(CLEAR_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                S_FAULT: begin
                    if (FAULT_CLR) begin
                        state_q <= S_IDLE;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                    d_q     <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign SW    = sw_q;
    assign D     = d_q;
    assign GRANT = grant_q;
    assign BUSY  = busy_q;
    assign FAULT = fault_q;

endmodule

// File: tb/tb_track_segment_arbiter.sv
// Directed and randomized checks of track_segment_arbiter against a
// cycle-level reference model of the segment scheduling rules.
module tb_track_segment_arbiter;

    localparam int N   = 2;
    localparam int ST  = 4;
    localparam int CL  = 2;
    localparam int MX  = 20;
    localparam int CW  = 16;
    localparam int SWW = 1;

    logic           Clock   = 1'b0;
    logic           RESET_N = 1'b1;
    logic [N-1:0]   req     = '0;
    logic [N-1:0]   ex      = '0;
    logic           fclr    = 1'b0;
    logic [SWW-1:0] sw;
    logic [2*N-1:0] d;
    logic [N-1:0]   grant;
    logic           busy;
    logic           fault;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode 0 free, 1 switch settling, 2 train on segment,
    // 3 dead time, 4 fault. age = cycles already spent in the mode.
    int m_mode, m_owner, m_ptr, m_sw, m_age;

    track_segment_arbiter #(
        .NUM_TRAINS    (N),
        .SETTLE_CYCLES (ST),
        .CLEAR_CYCLES  (CL),
        .MAX_OCC_CYCLES(MX),
        .CNT_W         (CW)
    ) dut (
        .Clock    (Clock),
        .RESET_N  (RESET_N),
        .REQ      (req),
        .EXIT     (ex),
        .FAULT_CLR(fclr),
        .SW       (sw),
        .D        (d),
        .GRANT    (grant),
        .BUSY     (busy),
        .FAULT    (fault)
    );

    always #5 Clock = ~Clock;

    function automatic void m_reset();
        m_mode  = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_sw    = 0;
        m_age   = 0;
    endfunction

    function automatic void m_step();
        int idx;
        case (m_mode)
            0: begin
                for (int i = 0; i < N; i++) begin
                    idx = (m_ptr + i) % N;
                    if (m_mode == 0 && req[idx]) begin
                        m_owner = idx;
                        m_sw    = idx;
                        m_mode  = 1;
                        m_age   = 0;
                    end
                end
            end
            1: begin
                if (!req[m_owner]) begin
                    m_mode  = 0;
                    m_owner = -1;
                end else if (m_age + 1 == ST) begin
                    m_mode = 2;
                    m_age  = 0;
                end else m_age++;
            end
            2: begin
                if (ex[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_mode  = 3;
                    m_age   = 0;
                end else if (m_age + 1 == MX) begin
                    m_owner = -1;
                    m_mode  = 4;
                    m_age   = 0;
                end else m_age++;
            end
            3: begin
                if (m_age + 1 == CL) m_mode = 0;
                else m_age++;
            end
            default: begin
                if (fclr) m_mode = 0;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        logic [31:0] eg, ed;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        ed = (m_mode == 2) ? (32'd1 << (2 * m_owner)) : 32'd0;
        chk("m_grant", 32'(grant), eg);
        chk("m_d",     32'(d),     ed);
        chk("m_sw",    32'(sw),    32'(m_sw));
        chk("m_busy",  32'(busy),  32'(m_mode != 0));
        chk("m_fault", 32'(fault), 32'(m_mode == 4));
    endtask

    task automatic tick();
        @(posedge Clock);
        m_step();
        #1;
        chk_model();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        #1;
        m_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_d",     32'(d),     32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk_model();
        @(posedge Clock);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        m_reset();
        #1;
        apply_reset();
        chk("rst_sw",    32'(sw),    32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        // 1: single grant, settle, exit, dead time
        req = 2'b01;
        tick();
        chk("t1_grant", 32'(grant), 32'b01);
        chk("t1_sw",    32'(sw),    32'd0);
        chk("t1_d_stop", 32'(d),    32'd0);
        cycles(3);
        chk("t1_d_pre", 32'(d),     32'd0);
        tick();
        chk("t1_d_go",  32'(d),     32'b0001);
        cycles(5);
        req = 2'b00;
        ex  = 2'b01;
        tick();
        ex  = 2'b00;
        chk("t1_d_exit", 32'(d),    32'd0);
        chk("t1_g_exit", 32'(grant), 32'd0);
        chk("t1_busy_clr", 32'(busy), 32'd1);
        cycles(2);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // 2: round robin from reset
        apply_reset();
        req = 2'b11;
        tick();
        chk("t2_g0", 32'(grant), 32'b01);
        cycles(4);
        chk("t2_d0", 32'(d), 32'b0001);
        ex  = 2'b01;
        req = 2'b10;
        tick();
        ex  = 2'b00;
        cycles(3);
        chk("t2_g1",  32'(grant), 32'b10);
        chk("t2_sw1", 32'(sw),    32'd1);
        cycles(4);
        chk("t2_d1", 32'(d), 32'b0100);
        ex  = 2'b10;
        req = 2'b11;
        tick();
        ex  = 2'b00;
        cycles(3);
        chk("t2_wrap", 32'(grant), 32'b01);

        // 3: occupancy timeout and operator clear
        apply_reset();
        req = 2'b10;
        tick();
        chk("t3_g1", 32'(grant), 32'b10);
        cycles(23);
        chk("t3_nofault", 32'(fault), 32'd0);
        chk("t3_d_go",    32'(d),     32'b0100);
        tick();
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_d",     32'(d),     32'd0);
        chk("t3_g",     32'(grant), 32'd0);
        req = 2'b00;
        cycles(3);
        chk("t3_latched", 32'(fault), 32'd1);
        fclr = 1'b1;
        tick();
        fclr = 1'b0;
        chk("t3_clr_fault", 32'(fault), 32'd0);
        chk("t3_clr_busy",  32'(busy),  32'd0);

        // 4: abort during settle
        req = 2'b01;
        tick();
        chk("t4_g", 32'(grant), 32'b01);
        req = 2'b00;
        tick();
        tick();
        chk("t4_abort_g", 32'(grant), 32'd0);
        chk("t4_abort_d", 32'(d),     32'd0);
        chk("t4_abort_b", 32'(busy),  32'd0);
        req = 2'b01;
        tick();
        chk("t4_regrant", 32'(grant), 32'b01);
        cycles(4);

        // 5: stray exit, request drop while occupied, exit on last cycle
        chk("t5_occ", 32'(d), 32'b0001);
        ex  = 2'b10;
        req = 2'b00;
        cycles(5);
        chk("t5_stray_d", 32'(d),     32'b0001);
        chk("t5_stray_g", 32'(grant), 32'b01);
        ex = 2'b00;
        cycles(14);
        ex = 2'b01;
        tick();
        ex = 2'b00;
        chk("t5_exit_fault", 32'(fault), 32'd0);
        chk("t5_exit_d",     32'(d),     32'd0);
        chk("t5_exit_busy",  32'(busy),  32'd1);
        cycles(2);

        // 6: asynchronous reset between edges while occupied
        req = 2'b10;
        cycles(8);
        chk("t6_occ", 32'(d), 32'b0100);
        #2;
        RESET_N = 1'b0;
        #1;
        m_reset();
        chk("t6_g", 32'(grant), 32'd0);
        chk("t6_d", 32'(d),     32'd0);
        chk("t6_b", 32'(busy),  32'd0);
        req = 2'b11;
        @(negedge Clock);
        RESET_N = 1'b1;
        tick();
        chk("t6_ptr0", 32'(grant), 32'b01);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            ex   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            fclr = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
